// File: rtl/call_register_if.sv
// Button, lift-status and request/door signals between the lift car controller side and call_register.
// The master side drives buttons and lift status; the slave side returns request bitmaps and the door command.
interface call_register_if #(
  parameter int NUM_FLOORS = 11
);
  logic [NUM_FLOORS-1:0] hall_btn;
  logic [NUM_FLOORS-1:0] cab_btn;
  logic [3:0]            lift_floor;
  logic [1:0]            motor_signal;
  logic [NUM_FLOORS-1:0] floor_req;
  logic [NUM_FLOORS-1:0] cab_pend;
  logic [NUM_FLOORS-1:0] hall_pend;
  logic                  door_open;
  logic                  busy;

  modport master (
    output hall_btn, cab_btn, lift_floor, motor_signal,
    input  floor_req, cab_pend, hall_pend, door_open, busy
  );

  modport slave (
    input  hall_btn, cab_btn, lift_floor, motor_signal,
    output floor_req, cab_pend, hall_pend, door_open, busy
  );
endinterface

// File: rtl/call_register.sv
// Latches hall/cab presses into per-floor pending bitmaps and runs the door dwell on arrival; 1-cycle press-to-request.
// No backpressure: presses are level-sampled every cycle and floor_req is masked while the door is open.
module call_register #(
  parameter int NUM_FLOORS   = 11,
  parameter int DWELL_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  call_register_if.slave  bus
);

  typedef enum logic {
    ST_CLOSED = 1'b0,
    ST_OPEN   = 1'b1
  } state_t;

  localparam logic [7:0] DWELL_RELOAD = 8'(DWELL_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_dwell_cnt;
  logic [7:0]            w_dwell_nxt;
  logic [NUM_FLOORS-1:0] r_prev_hall;
  logic [NUM_FLOORS-1:0] r_prev_cab;
  logic [NUM_FLOORS-1:0] r_hall_pend;
  logic [NUM_FLOORS-1:0] r_cab_pend;
  logic [NUM_FLOORS-1:0] w_hall_nxt;
  logic [NUM_FLOORS-1:0] w_cab_nxt;

  logic [NUM_FLOORS-1:0] w_hall_press;
  logic [NUM_FLOORS-1:0] w_cab_press;
  logic [NUM_FLOORS-1:0] w_pend;
  logic [NUM_FLOORS-1:0] w_sel;
  logic                  w_idle_motor;
  logic                  w_service;
  logic                  w_reopen;
  logic                  w_door_open;

  assign w_hall_press = bus.hall_btn & ~r_prev_hall;
  assign w_cab_press  = bus.cab_btn  & ~r_prev_cab;
  assign w_pend       = r_hall_pend | r_cab_pend;
  assign w_idle_motor = (bus.motor_signal == 2'b00);

  // One-hot of the current floor; all-zero when the reported floor is out of range.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_sel[i] = (bus.lift_floor == 4'(i));
    end
  end

  assign w_service = (r_state == ST_CLOSED) && w_idle_motor && (|(w_pend & w_sel));
  assign w_reopen  = (r_state == ST_OPEN) && (|((w_hall_press | w_cab_press) & w_sel));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLOSED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLOSED: begin
        if (w_service) begin
          w_state_nxt = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (!w_reopen && (r_dwell_cnt == 8'd0)) begin
          w_state_nxt = ST_CLOSED;
        end
      end
      default: w_state_nxt = ST_CLOSED;
    endcase
  end

  always_comb begin
    w_door_open = 1'b0;
    case (r_state)
      ST_OPEN:  w_door_open = 1'b1;
      default:  w_door_open = 1'b0;
    endcase
  end

  always_comb begin
    w_dwell_nxt = r_dwell_cnt;
    if (w_service || w_reopen) begin
      w_dwell_nxt = DWELL_RELOAD;
    end else if ((r_state == ST_OPEN) && (r_dwell_cnt != 8'd0)) begin
      w_dwell_nxt = r_dwell_cnt - 8'd1;
    end
  end

  // Service clears beat a same-edge press; while open, a press at the car's floor only restarts the dwell.
  always_comb begin
    w_hall_nxt = r_hall_pend | w_hall_press;
    w_cab_nxt  = r_cab_pend  | w_cab_press;
    if (w_service) begin
      w_hall_nxt = w_hall_nxt & ~w_sel;
      w_cab_nxt  = w_cab_nxt  & ~w_sel;
    end else if (r_state == ST_OPEN) begin
      w_hall_nxt = r_hall_pend | (w_hall_press & ~w_sel);
      w_cab_nxt  = r_cab_pend  | (w_cab_press  & ~w_sel);
    end
  end

  // prev resets to all-ones so a button held through reset needs a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_hall <= '1;
      r_prev_cab  <= '1;
      r_hall_pend <= '0;
      r_cab_pend  <= '0;
      r_dwell_cnt <= 8'd0;
    end else begin
      r_prev_hall <= bus.hall_btn;
      r_prev_cab  <= bus.cab_btn;
      r_hall_pend <= w_hall_nxt;
      r_cab_pend  <= w_cab_nxt;
      r_dwell_cnt <= w_dwell_nxt;
    end
  end

  assign bus.floor_req = w_pend & {NUM_FLOORS{~w_door_open}};
  assign bus.hall_pend = r_hall_pend;
  assign bus.cab_pend  = r_cab_pend;
  assign bus.door_open = w_door_open;
  assign bus.busy      = (|r_hall_pend) | (|r_cab_pend) | w_door_open;

endmodule

// File: tb/tb_call_register.sv
// Directed scenarios plus randomized traffic for call_register, checked against a cycle-level behavioural model.
module tb_call_register;
  localparam int NF = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  call_register_if #(.NUM_FLOORS(NF)) bus ();

  call_register #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending sets, previous button levels, cycles of door-open remaining.
  logic [NF-1:0] m_hall, m_cab, m_prev_h, m_prev_c;
  int            m_open_left;

  task automatic model_reset();
    m_hall = '0; m_cab = '0; m_prev_h = '1; m_prev_c = '1; m_open_left = 0;
  endtask

  task automatic model_edge();
    logic [NF-1:0] ph, pc;
    int fl;
    bit in_range;
    ph = bus.hall_btn & ~m_prev_h;
    pc = bus.cab_btn & ~m_prev_c;
    fl = int'(bus.lift_floor);
    in_range = (fl < NF);
    if (m_open_left == 0) begin
      m_hall |= ph;
      m_cab  |= pc;
      if (bus.motor_signal == 2'b00 && in_range && (ph[fl] | pc[fl] | 1'b1) &&
          ((m_hall[fl] & ~ph[fl]) | (m_cab[fl] & ~pc[fl]))) begin
        m_hall[fl] = 1'b0;
        m_cab[fl]  = 1'b0;
        m_open_left = DW;
      end
    end else begin
      if (in_range && (ph[fl] | pc[fl])) begin
        ph[fl] = 1'b0;
        pc[fl] = 1'b0;
        m_open_left = DW;
      end else begin
        m_open_left--;
      end
      m_hall |= ph;
      m_cab  |= pc;
    end
    m_prev_h = bus.hall_btn;
    m_prev_c = bus.cab_btn;
  endtask

  function automatic logic [3*NF+1:0] model_outs();
    logic door;
    door = (m_open_left > 0);
    return {(m_hall | m_cab) & {NF{~door}}, m_hall, m_cab, door,
            (|m_hall) | (|m_cab) | door};
  endfunction

  function automatic logic [3*NF+1:0] dut_outs();
    return {bus.floor_req, bus.hall_pend, bus.cab_pend, bus.door_open, bus.busy};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.hall_btn = '0; bus.cab_btn = '0;
    model_reset();
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.hall_btn = 11'h7FF; bus.cab_btn = '0;
    bus.lift_floor = 4'd4; bus.motor_signal = 2'b11;
    rst = 1'b1;
    model_reset();
    step(); step(); step();
    checks++;
    if (dut_outs() !== '0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0", dut_outs());
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.hall_pend !== '0 || bus.cab_pend !== '0 || bus.door_open !== 1'b0) begin
        failures++;
        $display("FAIL held_through_reset: hall_pend=%h cab_pend=%h door=%b expected 0/0/0",
                 bus.hall_pend, bus.cab_pend, bus.door_open);
      end
    end
    bus.hall_btn = 11'h7F7;
    step();
    bus.hall_btn = 11'h7FF;
    step();
    checks++;
    if (bus.hall_pend !== 11'h008 || bus.floor_req !== 11'h008) begin
      failures++;
      $display("FAIL repress_after_reset: hall_pend=%h floor_req=%h expected 008/008",
               bus.hall_pend, bus.floor_req);
    end
  endtask

  task automatic test_capture_mask();
    do_reset();
    bus.motor_signal = 2'b11; bus.lift_floor = 4'd4;
    step();
    bus.cab_btn = 11'h080; bus.hall_btn = 11'h004;
    step();
    checks++;
    if (bus.floor_req !== 11'h084) begin
      failures++;
      $display("FAIL capture_latency: floor_req=%h expected 084", bus.floor_req);
    end
    bus.cab_btn = '0; bus.hall_btn = '0;
    bus.motor_signal = 2'b10;
    step(); step();
    bus.motor_signal = 2'b01; bus.lift_floor = 4'd7;
    step(); step();
    checks++;
    if (bus.floor_req !== 11'h084 || bus.door_open !== 1'b0) begin
      failures++;
      $display("FAIL hold_while_moving: floor_req=%h door=%b expected 084/0",
               bus.floor_req, bus.door_open);
    end
  endtask

  task automatic test_service();
    bus.lift_floor = 4'd7; bus.motor_signal = 2'b00;
    for (int k = 0; k < DW; k++) begin
      step();
      checks++;
      if (bus.door_open !== 1'b1 || bus.floor_req !== '0) begin
        failures++;
        $display("FAIL service_dwell[%0d]: door=%b floor_req=%h expected 1/000",
                 k, bus.door_open, bus.floor_req);
      end
    end
    step();
    checks++;
    if (bus.door_open !== 1'b0 || bus.floor_req !== 11'h004 || bus.cab_pend[7] !== 1'b0) begin
      failures++;
      $display("FAIL service_close: door=%b floor_req=%h cab_pend=%h expected 0/004/bit7=0",
               bus.door_open, bus.floor_req, bus.cab_pend);
    end
  endtask

  task automatic test_reopen();
    int open_cnt = 0;
    int bad_pend = 0;
    bus.motor_signal = 2'b11;
    bus.cab_btn = 11'h080;
    step();
    bus.cab_btn = '0;
    step();
    bus.motor_signal = 2'b00; bus.lift_floor = 4'd7;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.hall_btn = (cyc == 6) ? 11'h080 : 11'h000;
      step();
      if (bus.door_open === 1'b1) begin
        open_cnt++;
        if (bus.hall_pend[7] !== 1'b0) bad_pend++;
      end else if (open_cnt > 0) begin
        break;
      end
    end
    bus.hall_btn = '0;
    checks++;
    if (open_cnt != DW + 5) begin
      failures++;
      $display("FAIL reopen_length: door high %0d cycles expected %0d", open_cnt, DW + 5);
    end
    checks++;
    if (bad_pend != 0) begin
      failures++;
      $display("FAIL reopen_no_latch: hall_pend[7] set in %0d cycles expected 0", bad_pend);
    end
    bus.motor_signal = 2'b11;
    step();
  endtask

  task automatic test_out_of_range();
    do_reset();
    bus.motor_signal = 2'b11; bus.lift_floor = 4'd4;
    step();
    bus.hall_btn = 11'h400;
    step();
    bus.hall_btn = '0;
    bus.lift_floor = 4'd12; bus.motor_signal = 2'b00;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) bus.lift_floor = 4'd15;
      step();
      checks++;
      if (bus.door_open !== 1'b0 || bus.hall_pend !== 11'h400 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL out_of_range[%0d]: door=%b hall_pend=%h busy=%b expected 0/400/1",
                 k, bus.door_open, bus.hall_pend, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    bus.motor_signal = 2'b11; bus.lift_floor = 4'd8;
    step();
    bus.hall_btn = 11'h011; bus.cab_btn = 11'h020;
    step();
    bus.hall_btn = '0; bus.cab_btn = '0;
    bus.lift_floor = 4'd5; bus.motor_signal = 2'b00;
    step(); step(); step();
    checks++;
    if (bus.door_open !== 1'b1 || bus.hall_pend !== 11'h011) begin
      failures++;
      $display("FAIL pre_reset_dwell: door=%b hall_pend=%h expected 1/011",
               bus.door_open, bus.hall_pend);
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.door_open !== 1'b0 || bus.busy !== 1'b0 || bus.hall_pend !== '0 ||
        bus.cab_pend !== '0 || bus.floor_req !== '0) begin
      failures++;
      $display("FAIL reset_mid_dwell: door=%b busy=%b hall=%h cab=%h req=%h expected all 0",
               bus.door_open, bus.busy, bus.hall_pend, bus.cab_pend, bus.floor_req);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bus.hall_btn = bus.hall_btn ^ NF'($urandom & $urandom & $urandom);
      bus.cab_btn  = bus.cab_btn  ^ NF'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) bus.lift_floor = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) bus.motor_signal = 2'($urandom_range(0, 3));
      step();
      checks++;
      if (dut_outs() !== model_outs()) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: dut {req,hall,cab,door,busy}=%h model=%h",
                   n, dut_outs(), model_outs());
      end
    end
  endtask

  initial begin
    bus.hall_btn = '0; bus.cab_btn = '0;
    bus.lift_floor = 4'd0; bus.motor_signal = 2'b11;
    model_reset();
    test_reset();
    test_capture_mask();
    test_service();
    test_reopen();
    test_out_of_range();
    test_reset_mid_dwell();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/call_register.md
# call_register

Request-capture and door-control stage that sits directly upstream of the lift car controller. It latches hall-call and in-cabin button presses into one pending-request bitmap per floor and drives that bitmap into the lift's floor-request input. It watches the lift's reported floor and motor state to detect arrival. On arrival it clears the served requests and holds the door open for a fixed dwell, masking requests so the car cannot depart while the door is open.

## Interface

Parameters:
- NUM_FLOORS, 11: number of floors, 0..NUM_FLOORS-1; sets the width of all bitmaps.
- DWELL_CYCLES, 8: clock cycles door_open stays high per service event; legal range 2..255.

Ports:
- clk, input, 1: single system clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- hall_btn, input, NUM_FLOORS: level from the hall call buttons; bit i is floor i.
- cab_btn, input, NUM_FLOORS: level from the cabin floor buttons; bit i is floor i.
- lift_floor, input, 4: current floor reported by the lift controller (its liftState).
- motor_signal, input, 2: lift motor state; 00 idle, 11 up, 10 down, 01 reserved and treated as moving.
- floor_req, output, NUM_FLOORS: pending-request bitmap fed to the lift; forced to all-zero while door_open=1.
- cab_pend, output, NUM_FLOORS: pending cabin requests, for button lamps; not masked.
- hall_pend, output, NUM_FLOORS: pending hall requests, for button lamps; not masked.
- door_open, output, 1: door command; 1 means open.
- busy, output, 1: 1 when any pending bit is set or door_open=1.

## Operation

- **Edge detection.** hall_btn and cab_btn are registered each cycle into prev_hall and prev_cab. A press is a rising edge: btn & ~prev.
  - A held button latches once.
  - A button held through reset does not latch until it is released and pressed again. prev resets to all-ones.
- **Latching.** A press on floor i sets hall_pend[i] or cab_pend[i] in the same clock edge. Both sets may occur in one cycle, on any number of floors.
- **Door FSM**, two states:
  - CLOSED: door_open=0.
    - Service condition: motor_signal==00, lift_floor<NUM_FLOORS, and (hall_pend|cab_pend)[lift_floor]==1.
    - When the condition holds, the FSM moves to OPEN. It clears hall_pend[lift_floor] and cab_pend[lift_floor], and loads dwell_cnt with DWELL_CYCLES-1.
  - OPEN: door_open=1. dwell_cnt decrements each cycle. When dwell_cnt==0, the FSM moves to CLOSED.
    - A press (hall or cab) at floor lift_floor while OPEN reloads dwell_cnt to DWELL_CYCLES-1 and does not set a pend bit. This is the re-open behaviour.
    - Presses at other floors latch normally.
- **floor_req** is combinational from registered state: (hall_pend|cab_pend) & {NUM_FLOORS{~door_open}}.
- **Out-of-range floor.** If lift_floor>=NUM_FLOORS, there is no service, no clear, and no error; pending state is held.
- **Reserved motor code.** motor_signal==01 never triggers service.
- **Precedence on one edge, same floor:**
  - In CLOSED, clear-by-service beats a simultaneous press. The passenger is being served.
  - In OPEN, a same-floor press is absorbed as a dwell restart.
- **busy** is combinational: |hall_pend | |cab_pend | door_open.

## Timing

- **Reset values:**
  - hall_pend=0, cab_pend=0, floor_req=0, door_open=0, busy=0.
  - FSM=CLOSED, dwell_cnt=0, prev_hall and prev_cab all ones.
- **Reset mid-dwell** drops door_open to 0 asynchronously and discards all pending requests.
- **Press latency.** A button sampled low at edge N-1 and high at edge N sets its pend bit at edge N. floor_req reflects it immediately after edge N, a 1-cycle press-to-request latency.
- **Service latency.** If the service condition holds at edge N:
  - door_open=1 and the served bits read 0 from edge N.
  - floor_req is all-zero from edge N to edge N+DWELL_CYCLES.
- **Dwell length.** Without a re-open, door_open is high for exactly DWELL_CYCLES cycles and falls at edge N+DWELL_CYCLES. Remaining pending bits reappear on floor_req in that same cycle.
- **Back-to-back service.** In the cycle after closing, if the service condition holds again (a new press at the same floor while CLOSED), service re-triggers with no idle gap required.
- **Re-open.** A re-open press at edge M extends door_open to fall at edge M+DWELL_CYCLES.

## Test plan

- **Reset:** assert rst with hall_btn=11'h7FF held; release and hold the buttons high 5 cycles -> all pend bits remain 0 and door_open=0. Drop and re-raise bit 3 -> hall_pend=11'h008 one edge later.
- **Capture and mask:** press cab_btn[7] and hall_btn[2] in the same cycle with motor_signal=11 and lift_floor=4 -> floor_req=11'h084 after 1 edge; bits held while motor_signal≠00.
- **Service:** floor_req=11'h084, drive lift_floor=7 and motor_signal=00 -> door_open=1 and floor_req=0 for exactly 8 cycles; afterwards floor_req=11'h004 and cab_pend[7]=0.
- **Re-open:** during the dwell at floor 7, press hall_btn[7] at dwell cycle 5 -> door_open stays high 8 more cycles (13 total); hall_pend[7] stays 0.
- **Out-of-range floor:** lift_floor=4'd12 with motor_signal=00 and pending 11'h400 -> no door open; pending unchanged.
- **Reset mid-dwell:** assert rst at dwell cycle 3 with pending 11'h011 -> door_open=0, busy=0, all pend bits 0 immediately.
